// File: rtl/nand_responder.sv
// nand_responder -- behavioural NAND flash target (single-chip responder).
//
// Decodes a small ONFI-like command set from the async controller bus: page
// read (00/30), page program (80/10), block erase (60/D0), read status (70)
// and reset (FF). The array and page buffer are plain registers so a
// controller can be exercised end to end without a flash model.
//
// Ports:
//   P_clk      sole clock, rising edge
//   P_rst      synchronous active-high reset
//   F_nCE      chip enable, active low
//   F_CLE      command latch enable
//   F_ALE      address latch enable
//   F_nWE      write strobe, latched on its rising edge
//   F_nRE      read strobe, data driven after its falling edge
//   F_nWP      write protect, active low
//   F_DIO_in   8-bit bus from controller
//   F_DIO_out  8-bit bus to controller (holds last value)
//   F_DIO_oe   output enable for F_DIO_out
//   F_nRB      ready/busy#, 0 = busy
module nand_responder #(
    parameter int PAGE_BYTES = 16,
    parameter int NUM_PAGES  = 4,
    parameter int T_R        = 20,
    parameter int T_PROG     = 40,
    parameter int T_ERASE    = 60,
    parameter int T_RST      = 10
) (
    input  logic       P_clk,
    input  logic       P_rst,
    input  logic       F_nCE,
    input  logic       F_CLE,
    input  logic       F_ALE,
    input  logic       F_nWE,
    input  logic       F_nRE,
    input  logic       F_nWP,
    input  logic [7:0] F_DIO_in,
    output logic [7:0] F_DIO_out,
    output logic       F_DIO_oe,
    output logic       F_nRB
);
    localparam int COL_W = (PAGE_BYTES > 1) ? $clog2(PAGE_BYTES) : 1;
    localparam int ROW_W = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
    localparam int T_A   = (T_R > T_PROG) ? T_R : T_PROG;
    localparam int T_B   = (T_ERASE > T_RST) ? T_ERASE : T_RST;
    localparam int T_MAX = (T_A > T_B) ? T_A : T_B;
    localparam int CNT_W = $clog2(T_MAX + 1);

    localparam logic [7:0] CMD_READ   = 8'h00;
    localparam logic [7:0] CMD_READC  = 8'h30;
    localparam logic [7:0] CMD_PROG   = 8'h80;
    localparam logic [7:0] CMD_PROGC  = 8'h10;
    localparam logic [7:0] CMD_ERASE  = 8'h60;
    localparam logic [7:0] CMD_ERASEC = 8'hD0;
    localparam logic [7:0] CMD_STATUS = 8'h70;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    // Synchronizer reset value: chip deselected, strobes idle high, WP inactive.
    localparam logic [13:0] SYNC_IDLE = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00};

    typedef enum logic [2:0] {IDLE, ADDR, DIN, BUSY, DOUT, STATUS} state_t;
    typedef enum logic [1:0] {OP_NONE, OP_READ, OP_PROG, OP_ERASE} op_t;
    typedef logic [PAGE_BYTES-1:0][7:0] page_t;

    // ---------------- input synchronizers and strobe edges ----------------
    logic [13:0] sync1, sync2;
    logic        we_q, re_q;
    logic        ce_s, cle_s, ale_s, we_s, re_s, wp_s;
    logic [7:0]  dio_s;

    always_ff @(posedge P_clk) begin
        if (P_rst) begin
            sync1 <= SYNC_IDLE;
            sync2 <= SYNC_IDLE;
            we_q  <= 1'b1;
            re_q  <= 1'b1;
        end else begin
            sync1 <= {F_nCE, F_CLE, F_ALE, F_nWE, F_nRE, F_nWP, F_DIO_in};
            sync2 <= sync1;
            we_q  <= we_s;
            re_q  <= re_s;
        end
    end

    assign {ce_s, cle_s, ale_s, we_s, re_s, wp_s, dio_s} = sync2;

    logic ev_ok, we_rise, re_fall, re_rise, cmd_ev, addr_ev, data_ev;
    // CLE and ALE together is an illegal bus phase; treat it like deselect.
    assign ev_ok   = ~ce_s & ~(cle_s & ale_s);
    assign we_rise = ev_ok & we_s & ~we_q;
    assign re_fall = ev_ok & ~re_s & re_q;
    assign re_rise = ev_ok & re_s & ~re_q;
    assign cmd_ev  = we_rise & cle_s;
    assign addr_ev = we_rise & ale_s;
    assign data_ev = we_rise & ~cle_s & ~ale_s;

    // ---------------- control state ----------------
    state_t             state;
    op_t                p_op;      // operation awaiting its confirm byte
    op_t                op;        // operation carried out when busy ends
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [15:0]        col_raw;
    logic [23:0]        row_raw;
    logic [2:0]         aidx;      // next address byte index, 5 = complete
    logic [CNT_W-1:0]   cnt;
    logic               fail;
    logic               stat_rd;   // 70 seen while busy: serve status reads
    page_t              pbuf;
    page_t              mem [NUM_PAGES];

    logic [7:0]       confirm_byte, status;
    logic             confirm_hit, status_cmd, reset_cmd, busy_done;
    logic [15:0]      col_nxt;
    logic [23:0]      row_nxt;
    logic [COL_W-1:0] col_mod, col_inc;
    logic [ROW_W-1:0] row_mod;

    always_comb begin
        confirm_byte = 8'h00;
        case (p_op)
            OP_READ:  confirm_byte = CMD_READC;
            OP_PROG:  confirm_byte = CMD_PROGC;
            OP_ERASE: confirm_byte = CMD_ERASEC;
            default:  confirm_byte = 8'h00;
        endcase
    end

    assign confirm_hit = cmd_ev && (state == ADDR || state == DIN) && aidx == 3'd5 &&
                         p_op != OP_NONE && dio_s == confirm_byte;
    assign status_cmd  = cmd_ev && dio_s == CMD_STATUS;
    assign reset_cmd   = cmd_ev && dio_s == CMD_RESET;
    // A reset command landing on the last busy cycle wins over completion.
    assign busy_done   = state == BUSY && cnt == '0 && !reset_cmd;
    assign status      = {wp_s, state != BUSY, 5'b0, fail};

    assign col_nxt = (aidx == 3'd0) ? {col_raw[15:8], dio_s} : {dio_s, col_raw[7:0]};
    always_comb begin
        row_nxt = row_raw;
        case (aidx)
            3'd2:    row_nxt = {row_raw[23:8], dio_s};
            3'd3:    row_nxt = {row_raw[23:16], dio_s, row_raw[7:0]};
            3'd4:    row_nxt = {dio_s, row_raw[15:0]};
            default: row_nxt = row_raw;
        endcase
    end
    assign col_mod = COL_W'(col_nxt % PAGE_BYTES);
    assign row_mod = ROW_W'(row_nxt % NUM_PAGES);
    assign col_inc = (col == COL_W'(PAGE_BYTES - 1)) ? '0 : col + 1'b1;

    always_ff @(posedge P_clk) begin
        if (P_rst) begin
            state     <= IDLE;
            p_op      <= OP_NONE;
            op        <= OP_NONE;
            col       <= '0;
            row       <= '0;
            col_raw   <= '0;
            row_raw   <= '0;
            aidx      <= '0;
            cnt       <= '0;
            fail      <= 1'b0;
            stat_rd   <= 1'b0;
            F_DIO_oe  <= 1'b0;
            F_DIO_out <= 8'h00;
            F_nRB     <= 1'b1;
        end else begin
            if (ce_s || cmd_ev || addr_ev)
                F_DIO_oe <= 1'b0;

            if (state == BUSY) begin
                // Countdown runs regardless of chip enable.
                if (reset_cmd) begin
                    cnt     <= CNT_W'(T_RST - 1);
                    op      <= OP_NONE;
                    stat_rd <= 1'b0;
                end else if (cnt == '0) begin
                    F_nRB <= 1'b1;
                    if (stat_rd || status_cmd)
                        state <= STATUS;
                    else if (op == OP_READ)
                        state <= DOUT;
                    else
                        state <= IDLE;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                if (status_cmd)
                    stat_rd <= 1'b1;
                if (re_fall && stat_rd) begin
                    F_DIO_oe  <= 1'b1;
                    F_DIO_out <= status;
                end
            end else if (cmd_ev) begin
                if (confirm_hit) begin
                    state   <= BUSY;
                    F_nRB   <= 1'b0;
                    stat_rd <= 1'b0;
                    p_op    <= OP_NONE;
                    case (p_op)
                        OP_READ: begin
                            cnt <= CNT_W'(T_R - 1);
                            op  <= OP_READ;
                        end
                        OP_PROG: begin
                            cnt  <= CNT_W'(T_PROG - 1);
                            op   <= wp_s ? OP_PROG : OP_NONE;
                            fail <= ~wp_s;
                        end
                        default: begin
                            cnt  <= CNT_W'(T_ERASE - 1);
                            op   <= wp_s ? OP_ERASE : OP_NONE;
                            fail <= ~wp_s;
                        end
                    endcase
                end else begin
                    // Anything else discards a pending operation and is decoded fresh.
                    p_op <= OP_NONE;
                    case (dio_s)
                        CMD_READ: begin
                            state <= ADDR;
                            p_op  <= OP_READ;
                            aidx  <= 3'd0;
                        end
                        CMD_PROG: begin
                            state <= ADDR;
                            p_op  <= OP_PROG;
                            aidx  <= 3'd0;
                            fail  <= 1'b0;
                        end
                        CMD_ERASE: begin
                            // Erase takes row bytes only.
                            state <= ADDR;
                            p_op  <= OP_ERASE;
                            aidx  <= 3'd2;
                            fail  <= 1'b0;
                        end
                        CMD_STATUS: state <= STATUS;
                        CMD_RESET: begin
                            state   <= BUSY;
                            F_nRB   <= 1'b0;
                            cnt     <= CNT_W'(T_RST - 1);
                            op      <= OP_NONE;
                            stat_rd <= 1'b0;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end else if (addr_ev) begin
                if (state == ADDR && aidx != 3'd5) begin
                    aidx <= aidx + 3'd1;
                    if (aidx < 3'd2) begin
                        col_raw <= col_nxt;
                        col     <= col_mod;
                    end else begin
                        row_raw <= row_nxt;
                        row     <= row_mod;
                    end
                    if (aidx == 3'd4 && p_op == OP_PROG)
                        state <= DIN;
                end
            end else if (data_ev) begin
                if (state == DIN)
                    col <= col_inc;
            end else if (re_fall) begin
                if (state == DOUT) begin
                    F_DIO_oe  <= 1'b1;
                    F_DIO_out <= pbuf[col];
                end else if (state == STATUS) begin
                    F_DIO_oe  <= 1'b1;
                    F_DIO_out <= status;
                end
            end else if (re_rise) begin
                if (state == DOUT)
                    col <= col_inc;
            end
        end
    end

    // Array and page buffer are storage only: reset leaves them untouched,
    // it merely suppresses the write that would have happened this edge.
    always_ff @(posedge P_clk) begin
        if (!P_rst) begin
            if (busy_done) begin
                case (op)
                    OP_READ:  pbuf     <= mem[row];
                    OP_PROG:  mem[row] <= pbuf;
                    OP_ERASE: mem[row] <= '1;
                    default:  ;
                endcase
            end else if (data_ev && state == DIN) begin
                pbuf[col] <= dio_s;
            end
        end
    end
endmodule

// File: tb/tb_nand_responder.sv
module tb_nand_responder;
    localparam int PB = 16, NP = 4, TR = 20, TP = 40, TE = 60, TRS = 10;

    logic       P_clk = 1'b0;
    logic       P_rst = 1'b1;
    logic       F_nCE = 1'b1, F_CLE = 1'b0, F_ALE = 1'b0;
    logic       F_nWE = 1'b1, F_nRE = 1'b1, F_nWP = 1'b1;
    logic [7:0] F_DIO_in = 8'h00;
    logic [7:0] F_DIO_out;
    logic       F_DIO_oe, F_nRB;

    always #5 P_clk = ~P_clk;

    nand_responder #(.PAGE_BYTES(PB), .NUM_PAGES(NP), .T_R(TR), .T_PROG(TP),
                     .T_ERASE(TE), .T_RST(TRS)) dut (
        .P_clk(P_clk), .P_rst(P_rst), .F_nCE(F_nCE), .F_CLE(F_CLE), .F_ALE(F_ALE),
        .F_nWE(F_nWE), .F_nRE(F_nRE), .F_nWP(F_nWP), .F_DIO_in(F_DIO_in),
        .F_DIO_out(F_DIO_out), .F_DIO_oe(F_DIO_oe), .F_nRB(F_nRB));

    // Busy-cycle meter: negedges seen with F_nRB low.
    int lowcnt = 0;
    always @(negedge P_clk) if (!F_nRB) lowcnt++;

    int snap;
    int n_vec = 0, n_err = 0;

    typedef enum {K_CMD, K_ADDR, K_DATA, K_RD, K_RDNO, K_WAIT, K_WAITNC, K_WP, K_CE, K_RB} kind_e;
    typedef struct {
        kind_e      k;
        logic [7:0] v;
        int         exp;
        string      name;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input kind_e k, input logic [7:0] v, input int exp, input string name);
        vec_t e;
        e.k = k; e.v = v; e.exp = exp; e.name = name;
        tbl.push_back(e);
    endfunction

    function automatic void add_addr5(input logic [7:0] c, input logic [7:0] r);
        add(K_ADDR, c, 0, ""); add(K_ADDR, 8'h00, 0, "");
        add(K_ADDR, r, 0, ""); add(K_ADDR, 8'h00, 0, ""); add(K_ADDR, 8'h00, 0, "");
    endfunction

    function automatic void add_read(input logic [7:0] c, input logic [7:0] r, input string name);
        add(K_CMD, 8'h00, 0, "");
        add_addr5(c, r);
        add(K_CMD, 8'h30, 0, "");
        add(K_WAIT, 8'h00, TR, name);
    endfunction

    // One write cycle; snapshot of the busy meter is taken at the edge where
    // the DUT acts on the latched byte (two sync flops + edge detect).
    task automatic bus_wr(input logic c, input logic a, input logic [7:0] v);
        @(posedge P_clk); #1;
        F_CLE = c; F_ALE = a; F_DIO_in = v; F_nWE = 1'b0;
        repeat (3) @(posedge P_clk);
        #1 F_nWE = 1'b1;
        repeat (3) @(posedge P_clk);
        snap = lowcnt;
        #1 F_CLE = 1'b0; F_ALE = 1'b0;
    endtask

    task automatic rd(output logic [7:0] d, output logic o);
        @(posedge P_clk); #1 F_nRE = 1'b0;
        repeat (4) @(posedge P_clk);
        @(negedge P_clk);
        d = F_DIO_out; o = F_DIO_oe;
        @(posedge P_clk); #1 F_nRE = 1'b1;
        repeat (4) @(posedge P_clk);
    endtask

    task automatic wait_ready(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge P_clk);
            if (F_nRB) begin ok = 1'b1; break; end
        end
        if (!ok) check({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       o;

        // Erase row 1, read it back as all 0xFF.
        add(K_CMD, 8'h60, 0, ""); add(K_ADDR, 8'h01, 0, "");
        add(K_ADDR, 8'h00, 0, ""); add(K_ADDR, 8'h00, 0, "");
        add(K_CMD, 8'hD0, 0, ""); add(K_WAIT, 8'h00, TE, "erase_busy");
        add_read(8'd0, 8'd1, "read_busy");
        for (int i = 0; i < PB; i++) add(K_RD, 8'h00, 8'hFF, $sformatf("erased_b%0d", i));
        // Program row 2 with 0..15, read from column 14 across the wrap.
        add(K_CMD, 8'h80, 0, ""); add_addr5(8'd0, 8'd2);
        for (int i = 0; i < PB; i++) add(K_DATA, 8'(i), 0, "");
        add(K_CMD, 8'h10, 0, ""); add(K_WAIT, 8'h00, TP, "prog_busy");
        add_read(8'd14, 8'd2, "read2_busy");
        add(K_RD, 0, 8'h0E, "wrap_0"); add(K_RD, 0, 8'h0F, "wrap_1");
        add(K_RD, 0, 8'h00, "wrap_2"); add(K_RD, 0, 8'h01, "wrap_3");
        // Deselected: RE ignored and output disabled, column held.
        add(K_CE, 8'h01, 0, ""); add(K_RDNO, 0, 0, "nce_no_drive");
        add(K_CE, 8'h00, 0, ""); add(K_RD, 0, 8'h02, "nce_col_held");
        // Write-protected program: row unchanged, fail set, cleared by next 80.
        add(K_WP, 8'h00, 0, ""); add(K_CMD, 8'h80, 0, ""); add_addr5(8'd0, 8'd2);
        add(K_DATA, 8'hAA, 0, ""); add(K_DATA, 8'h55, 0, "");
        add(K_CMD, 8'h10, 0, ""); add(K_WAITNC, 0, 0, "wp_prog");
        add(K_CMD, 8'h70, 0, ""); add(K_RD, 0, 8'h41, "wp_status");
        add_read(8'd0, 8'd2, "wp_read_busy");
        add(K_RD, 0, 8'h00, "wp_keep_0"); add(K_RD, 0, 8'h01, "wp_keep_1");
        add(K_WP, 8'h01, 0, ""); add(K_CMD, 8'h80, 0, "");
        add(K_CMD, 8'h70, 0, ""); add(K_RD, 0, 8'hC0, "fail_cleared");
        // Status during program busy, then after completion.
        add(K_CMD, 8'h80, 0, ""); add_addr5(8'd0, 8'd3); add(K_DATA, 8'h5A, 0, "");
        add(K_CMD, 8'h10, 0, ""); add(K_CMD, 8'h70, 0, "");
        add(K_RD, 0, 8'h80, "status_busy"); add(K_WAITNC, 0, 0, "prog3");
        add(K_RD, 0, 8'hC0, "status_ready");
        // Read with wrong confirm: no busy, back to IDLE.
        add(K_CMD, 8'h00, 0, ""); add_addr5(8'd0, 8'd2); add(K_CMD, 8'h10, 0, "");
        add(K_RB, 0, 1, "badconf_rb"); add(K_WAIT, 0, 0, "badconf_nobusy");
        add(K_RDNO, 0, 0, "badconf_idle");
        // Reset command during erase busy aborts the erase.
        add(K_CMD, 8'h60, 0, ""); add(K_ADDR, 8'h02, 0, "");
        add(K_ADDR, 8'h00, 0, ""); add(K_ADDR, 8'h00, 0, "");
        add(K_CMD, 8'hD0, 0, ""); add(K_CMD, 8'hFF, 0, "");
        add(K_WAIT, 0, TRS, "ff_busy");
        add_read(8'd0, 8'd2, "abort_read_busy");
        add(K_RD, 0, 8'h00, "abort_keep_0"); add(K_RD, 0, 8'h01, "abort_keep_1");

        // Reset state.
        repeat (3) @(posedge P_clk);
        #1 P_rst = 1'b0;
        check("rst_oe", F_DIO_oe, 0);
        check("rst_rb", F_nRB, 1);
        check("rst_dout", F_DIO_out, 0);
        F_nCE = 1'b0;

        foreach (tbl[i]) begin
            case (tbl[i].k)
                K_CMD:  bus_wr(1'b1, 1'b0, tbl[i].v);
                K_ADDR: bus_wr(1'b0, 1'b1, tbl[i].v);
                K_DATA: bus_wr(1'b0, 1'b0, tbl[i].v);
                K_RD: begin
                    rd(d, o);
                    check({tbl[i].name, "_oe"}, o, 1);
                    check(tbl[i].name, d, tbl[i].exp);
                end
                K_RDNO: begin
                    rd(d, o);
                    check(tbl[i].name, o, 0);
                end
                K_WAIT: begin
                    wait_ready(tbl[i].name);
                    check(tbl[i].name, lowcnt - snap, tbl[i].exp);
                end
                K_WAITNC: wait_ready(tbl[i].name);
                K_WP: begin
                    @(posedge P_clk); #1 F_nWP = tbl[i].v[0];
                    repeat (3) @(posedge P_clk);
                end
                K_CE: begin
                    @(posedge P_clk); #1 F_nCE = tbl[i].v[0];
                    repeat (4) @(posedge P_clk);
                end
                K_RB: begin
                    @(negedge P_clk);
                    check(tbl[i].name, F_nRB, tbl[i].exp);
                end
                default: ;
            endcase
        end

        // P_rst mid-DOUT while the bus is being driven (column now 2).
        @(posedge P_clk); #1 F_nRE = 1'b0;
        repeat (4) @(posedge P_clk);
        #1;
        check("pre_rst_oe", F_DIO_oe, 1);
        check("pre_rst_dout", F_DIO_out, 8'h02);
        P_rst = 1'b1;
        @(posedge P_clk); #1 P_rst = 1'b0;
        check("dout_rst_oe", F_DIO_oe, 0);
        check("dout_rst_rb", F_nRB, 1);
        check("dout_rst_dout", F_DIO_out, 0);
        F_nRE = 1'b1;
        repeat (4) @(posedge P_clk);
        rd(d, o);
        check("dout_rst_idle", o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
